// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 16-bit SRAM controller.
// Imported by the interface and the controller.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int          SRAM_WAIT_DEF = 1;
    localparam logic [31:0] MEM_BASE_DEF  = 32'd1024;
    localparam int          WORD_W        = 17;
    localparam int          HADDR_W       = 18;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline MEM-stage request bus and SRAM pad signals.
// master = pipeline/pad side, slave = controller.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [HADDR_W-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport master (
        output mem_r_en, mem_w_en, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses.
// ready drops for the whole access so the pipeline freezes.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          SRAM_WAIT = SRAM_WAIT_DEF,
    parameter logic [31:0] MEM_BASE  = MEM_BASE_DEF
) (
    input logic              clk,
    input logic              rst,
    sram_controller_if.slave bus
);

    localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);

    state_t             state, state_d;
    logic [3:0]         cnt, cnt_d;
    logic               op_wr, op_wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [HADDR_W-1:0] saddr_q, saddr_d;
    logic [15:0]        dq_q, dq_d;
    logic               oe_q, oe_d;
    logic               we_n_q, we_n_d;
    logic [31:0]        eff;
    logic [WORD_W-1:0]  word;
    logic               req;
    logic               last;
    logic               unused_eff;

    assign req  = bus.mem_r_en | bus.mem_w_en;
    assign last = (cnt == LAST);

    // Sequencing of the two halves plus request and read-data capture
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 4'd1;
        op_wr_d = op_wr;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    state_d = LOW;
                    op_wr_d = bus.mem_w_en;
                    addr_d  = bus.address;
                    wdata_d = bus.wdata;
                end
            end
            LOW: begin
                if (last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!op_wr) rdata_d[15:0] = bus.sram_dq_in;
                end
            end
            HIGH: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_wr) rdata_d[31:16] = bus.sram_dq_in;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Low 2 bits select the byte; bits above 18 fall off so the index wraps
    assign eff        = addr_d - MEM_BASE;
    assign word       = eff[18:2];
    assign unused_eff = ^{eff[31:19], eff[1:0]};

    // Pad values for the coming cycle; address and data hold when idle
    always_comb begin
        saddr_d = saddr_q;
        dq_d    = dq_q;
        oe_d    = 1'b0;
        we_n_d  = 1'b1;
        if (state_d == LOW || state_d == HIGH) begin
            saddr_d = {word, state_d == HIGH};
            if (op_wr_d) begin
                oe_d   = 1'b1;
                we_n_d = 1'b0;
                dq_d   = (state_d == HIGH) ? wdata_d[31:16]
                                           : wdata_d[15:0];
            end
        end
    end

    // State and registered pad outputs; reset aborts any access
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            saddr_q <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            op_wr   <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            saddr_q <= saddr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
        end
    end

    assign bus.ready       = (state == DONE) || (state == IDLE && !req);
    assign bus.rdata       = rdata_q;
    assign bus.sram_addr   = saddr_q;
    assign bus.sram_dq_out = dq_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two DUTs (SRAM_WAIT 1 and 3) with SRAM pads,
// a cycle-offset reference model per DUT and directed literal checks.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic        r_en    [2];
    logic        w_en    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic        ready_o [2];
    logic [31:0] rdata_o [2];
    logic [17:0] saddr_o [2];
    logic [15:0] dq_o    [2];
    logic        oe_o    [2];
    logic        wen_o   [2];

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W = (g == 0) ? 1 : 3;

        sram_controller_if bus ();

        sram_controller #(
            .SRAM_WAIT(W),
            .MEM_BASE (BASE)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );

        assign bus.mem_r_en = r_en[g];
        assign bus.mem_w_en = w_en[g];
        assign bus.address  = addr_i[g];
        assign bus.wdata    = wdata_i[g];
        assign ready_o[g]   = bus.ready;
        assign rdata_o[g]   = bus.rdata;
        assign saddr_o[g]   = bus.sram_addr;
        assign dq_o[g]      = bus.sram_dq_out;
        assign oe_o[g]      = bus.sram_dq_oe;
        assign wen_o[g]     = bus.sram_we_n;

        logic [15:0] pad   [int];
        logic [15:0] ref_h [int];

        bit          act, armed, m_wr;
        int          k, st;
        logic [31:0] m_addr, m_wdata, e_rdata;
        logic [17:0] e_saddr;
        logic [15:0] e_dq;

        initial begin
            pad[2] = 16'h5678;
            pad[3] = 16'h1234;
            ref_h[2] = 16'h5678;
            ref_h[3] = 16'h1234;
            act = 0; armed = 0; m_wr = 0; k = 0; st = 0;
            m_addr = 0; m_wdata = 0; e_rdata = 0; e_saddr = 0; e_dq = 0;
        end

        // SRAM pad: write strobe stores at the clock edge
        always @(posedge clk) begin
            if (bus.sram_we_n === 1'b0)
                pad[int'(bus.sram_addr)] = bus.sram_dq_out;
        end

        // SRAM pad: asynchronous read settles mid-cycle
        always @(negedge clk) begin
            bus.sram_dq_in = pad.exists(int'(bus.sram_addr)) ?
                pad[int'(bus.sram_addr)] : 16'h0;
        end

        // Reference model by cycle offset from request, then compare
        always @(negedge clk) begin
            int          off, word;
            bit          lo, hi, dn, e_ready, e_we_n, e_oe;
            logic [31:0] eff;
            string       tag;
            if (!act && (bus.mem_r_en || bus.mem_w_en)) begin
                act     = 1;
                st      = k;
                m_wr    = bus.mem_w_en;
                m_addr  = bus.address;
                m_wdata = bus.wdata;
            end
            eff  = m_addr - BASE;
            word = int'(eff >> 2) % 131072;
            off  = act ? k - st : -1;
            lo   = off >= 1 && off <= W;
            hi   = off > W && off <= 2 * W;
            dn   = off == 2 * W + 1;
            e_ready = dn || !act;
            e_we_n  = 1;
            e_oe    = 0;
            if (lo || hi) begin
                e_saddr = 18'(2 * word + (hi ? 1 : 0));
                if (m_wr) begin
                    e_we_n = 0;
                    e_oe   = 1;
                    e_dq   = hi ? m_wdata[31:16] : m_wdata[15:0];
                end
            end
            if (armed) begin
                tag = $sformatf("lane%0d cyc%0d", g, k);
                chk({tag, " ready"}, bus.ready, e_ready);
                chk({tag, " we_n"}, bus.sram_we_n, e_we_n);
                chk({tag, " dq_oe"}, bus.sram_dq_oe, e_oe);
                chk({tag, " sram_addr"}, bus.sram_addr, e_saddr);
                chk({tag, " dq_out"}, bus.sram_dq_out, e_dq);
                chk({tag, " rdata"}, bus.rdata, e_rdata);
            end
            if (act && off == 0 && m_wr) begin
                ref_h[2 * word]     = m_wdata[15:0];
                ref_h[2 * word + 1] = m_wdata[31:16];
            end
            if (act && off == W && !m_wr)
                e_rdata[15:0] = ref_h.exists(2 * word) ?
                    ref_h[2 * word] : 16'h0;
            if (act && off == 2 * W && !m_wr)
                e_rdata[31:16] = ref_h.exists(2 * word + 1) ?
                    ref_h[2 * word + 1] : 16'h0;
            if (dn) act = 0;
            if (rst) begin
                act     = 0;
                e_rdata = 0;
                e_saddr = 0;
                e_dq    = 0;
                armed   = 1;
            end
            k++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic run(input int ln, input bit wr, input bit rd,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rv, output int lat);
        tick();
        w_en[ln]    = wr;
        r_en[ln]    = rd;
        addr_i[ln]  = a;
        wdata_i[ln] = d;
        lat = -1;
        for (int n = 0; n < 64; n++) begin
            look();
            if (n > 0 && ready_o[ln]) begin
                lat = n;
                break;
            end
            tick();
            w_en[ln] = 0;
            r_en[ln] = 0;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d timeout: no ready in 64 cycles", ln);
        end
        rv = rdata_o[ln];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            r_en[i] = 0; w_en[i] = 0; addr_i[i] = BASE; wdata_i[i] = 0;
        end
        rst = 1;
        tick();
        tick();
        rst = 0;
        look();
        chk("reset ready", ready_o[0], 1);
        chk("reset we_n", wen_o[0], 1);
        chk("reset dq_oe", oe_o[0], 0);
        chk("reset rdata", rdata_o[0], 0);
        chk("reset sram_addr", saddr_o[0], 0);

        // write 0xDEADBEEF at base
        tick();
        w_en[0] = 1; addr_i[0] = 32'd1024; wdata_i[0] = 32'hDEADBEEF;
        look();
        chk("wr c0 ready", ready_o[0], 0);
        tick();
        w_en[0] = 0;
        look();
        chk("wr c1 sram_addr", saddr_o[0], 0);
        chk("wr c1 dq_out", dq_o[0], 16'hBEEF);
        chk("wr c1 we_n", wen_o[0], 0);
        tick();
        look();
        chk("wr c2 sram_addr", saddr_o[0], 1);
        chk("wr c2 dq_out", dq_o[0], 16'hDEAD);
        tick();
        look();
        chk("wr c3 ready", ready_o[0], 1);

        // read 1028 from preloaded halfwords 2/3
        tick();
        r_en[0] = 1; addr_i[0] = 32'd1028;
        look();
        chk("rd c0 ready", ready_o[0], 0);
        tick();
        r_en[0] = 0;
        look();
        chk("rd c1 we_n", wen_o[0], 1);
        tick();
        look();
        chk("rd c2 we_n", wen_o[0], 1);
        tick();
        look();
        chk("rd c3 ready", ready_o[0], 1);
        chk("rd c3 rdata", rdata_o[0], 32'h12345678);

        // both enables: write wins, rdata untouched
        run(0, 1, 1, 32'd1032, 32'hCAFEF00D, rv, lat);
        chk("both latency", lat, 3);
        chk("both rdata kept", rv, 32'h12345678);
        run(0, 0, 1, 32'd1032, 32'h0, rv, lat);
        chk("both readback", rv, 32'hCAFEF00D);

        // address below base wraps
        tick();
        w_en[0] = 1; addr_i[0] = 32'd0; wdata_i[0] = 32'h13579BDF;
        look();
        tick();
        w_en[0] = 0;
        look();
        chk("wrap lo addr", saddr_o[0], 18'h3FE00);
        tick();
        look();
        chk("wrap hi addr", saddr_o[0], 18'h3FE01);
        tick();
        look();
        run(0, 0, 1, 32'd0, 32'h0, rv, lat);
        chk("wrap readback", rv, 32'h13579BDF);

        // request held through DONE starts a new access from IDLE
        tick();
        r_en[0] = 1; addr_i[0] = 32'd1028;
        look();
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 5) r_en[0] = 0;
            look();
            if (c == 3) chk("hold c3 ready", ready_o[0], 1);
            if (c == 4) chk("hold c4 ready", ready_o[0], 0);
        end
        chk("hold c7 ready", ready_o[0], 1);
        chk("hold c7 rdata", rdata_o[0], 32'h12345678);

        // request dropped in LOW still completes
        run(0, 1, 0, 32'd1036, 32'h0BADC0DE, rv, lat);
        chk("drop latency", lat, 3);
        tick();
        look();
        chk("drop idle ready", ready_o[0], 1);
        run(0, 0, 1, 32'd1036, 32'h0, rv, lat);
        chk("drop readback", rv, 32'h0BADC0DE);

        // reset during HIGH of a write
        tick();
        w_en[0] = 1; addr_i[0] = 32'd1040; wdata_i[0] = 32'h11112222;
        look();
        tick();
        w_en[0] = 0;
        look();
        tick();
        rst = 1;
        look();
        chk("rst high we_n", wen_o[0], 0);
        tick();
        rst = 0;
        look();
        chk("rst ready", ready_o[0], 1);
        chk("rst we_n", wen_o[0], 1);
        chk("rst dq_oe", oe_o[0], 0);
        chk("rst rdata", rdata_o[0], 0);

        // SRAM_WAIT = 3 read
        tick();
        r_en[1] = 1; addr_i[1] = 32'd1028;
        look();
        chk("w3 c0 ready", ready_o[1], 0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            r_en[1] = 0;
            look();
            if (c < 7) chk($sformatf("w3 c%0d ready", c), ready_o[1], 0);
            if (c <= 3) chk($sformatf("w3 c%0d addr", c), saddr_o[1], 2);
            if (c >= 4 && c <= 6)
                chk($sformatf("w3 c%0d addr", c), saddr_o[1], 3);
        end
        chk("w3 c7 ready", ready_o[1], 1);
        chk("w3 c7 rdata", rdata_o[1], 32'h12345678);
        run(1, 1, 0, 32'd1044, 32'hA5A55A5A, rv, lat);
        chk("w3 write latency", lat, 7);
        run(1, 0, 1, 32'd1044, 32'h0, rv, lat);
        chk("w3 readback", rv, 32'hA5A55A5A);

        tick();
        look();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter SHALL be SRAM_WAIT, default 1, legal range 1..15: SRAM cycles held per 16-bit half access.
REQ-002 Parameter SHALL be MEM_BASE, default 32'd1024: pipeline byte address mapped to SRAM word 0.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  load request from the MEM stage.
- mem_w_en  in  1  store request from the MEM stage.
- address  in  32  byte address (ALU result).
- wdata  in  32  store value.
- rdata  out  32  load result.
- ready  out  1  access complete; the pipeline freezes while it is 0.
- sram_addr  out  18  SRAM halfword address.
- sram_dq_out  out  16  write data to the pad.
- sram_dq_in  in  16  read data from the pad.
- sram_dq_oe  out  1  pad output enable.
- sram_we_n  out  1  SRAM write strobe, active low.

Function
REQ-004 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-005 IDLE SHALL accept a request when mem_r_en or mem_w_en is 1, go to LOW, and latch address, wdata and op; mem_w_en SHALL win when both are 1.
REQ-006 LOW and HIGH SHALL each last exactly SRAM_WAIT cycles, counted by a 4-bit counter cleared on every state entry. LOW SHALL go to HIGH, HIGH SHALL go to DONE, and DONE SHALL go to IDLE after 1 cycle.
REQ-007 Address mapping: eff = latched address - MEM_BASE; sram_addr = {eff[18:2], 1'b0} in LOW and {eff[18:2], 1'b1} in HIGH. In IDLE and DONE, sram_addr SHALL hold its last value.
REQ-008 Write op: sram_dq_oe = 1 and sram_we_n = 0 throughout LOW and HIGH. sram_dq_out = wdata[15:0] in LOW and wdata[31:16] in HIGH.
REQ-009 Read op: sram_dq_oe = 0 and sram_we_n = 1. rdata[15:0] SHALL capture sram_dq_in on the last LOW cycle, and rdata[31:16] on the last HIGH cycle.
REQ-010 Outside LOW and HIGH, sram_we_n SHALL be 1 and sram_dq_oe SHALL be 0.
REQ-011 ready SHALL be combinational: 1 in DONE, 1 in IDLE with no request, 0 otherwise.
REQ-012 Latency: a request seen in IDLE at cycle 0 SHALL give ready = 1 at cycle 2*SRAM_WAIT+1.
REQ-013 rdata SHALL be valid in DONE and held until the next read overwrites it; writes SHALL NOT change rdata.
REQ-014 A request dropped mid-access (flush) SHALL NOT abort the access; the FSM completes through DONE.
REQ-015 A request still asserted in DONE SHALL be treated as the same access; a new access SHALL start only from IDLE on the following cycle.
REQ-016 Addresses below MEM_BASE SHALL wrap modulo 2^17 words with no error signal.

Reset
REQ-017 rst SHALL override every event, including an access in progress. It SHALL force state IDLE, counter 0, rdata 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0 and sram_we_n 1, so ready = 1 if no request is present. A partially written SRAM word is left as is.

Structure
REQ-018 A shared package SHALL hold the state enum, the SRAM_WAIT default, MEM_BASE, and the address widths (17-bit word index, 18-bit halfword address).
REQ-019 The block SHALL be a single module with no sub-module; the top level SHALL feed ready into the hazard freeze.

Verification
REQ-020 Write address 1024, wdata 0xDEADBEEF, SRAM_WAIT = 1 -> cycle 1: sram_addr 0, dq_out 0xBEEF, we_n 0; cycle 2: sram_addr 1, dq_out 0xDEAD; ready = 1 at cycle 3.
REQ-021 Read address 1028 with the SRAM model holding halfwords 2 = 0x5678 and 3 = 0x1234 -> rdata 0x12345678 and ready = 1 at cycle 3; we_n stays 1.
REQ-022 SRAM_WAIT = 3, read -> ready = 0 for cycles 0..6 and 1 at cycle 7; each halfword address is held for 3 cycles.
REQ-023 mem_r_en and mem_w_en both 1 -> write performed; rdata unchanged.
REQ-024 rst asserted in HIGH of a write -> next cycle IDLE, we_n 1, dq_oe 0, rdata 0, ready 1.
REQ-025 Request dropped in LOW -> access completes, DONE reached at cycle 3, then IDLE with ready = 1.
